adder_sweep_sequencer: RTL
==========================

ADDER_SWEEP_SEQUENCER -- requirements
Module: adder_sweep_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: operand width driven to the ROM adder.
REQ-002 Parameter DATA_WIDTH, default 9: sum width returned by the ROM adder (ADDR_WIDTH+1).
REQ-003 Parameter READ_LATENCY, default 1: clock edges from operand change to valid sum.
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle sweep request.
REQ-007 a  output  ADDR_WIDTH  operand A to the adder, registered.
REQ-008 b  output  ADDR_WIDTH  operand B to the adder, registered.
REQ-009 sum  input  DATA_WIDTH  sum returned by the adder.
REQ-010 busy  output  1  high while in RUN or DRAIN.
REQ-011 done  output  1  sweep complete, held until the next accepted start or reset.
REQ-012 pass  output  1  valid with done; high iff err_count is zero.
REQ-013 err_count  output  16  mismatch count, saturating.
REQ-014 first_err_a, first_err_b  output  ADDR_WIDTH each  operands of the first mismatch.

Function
REQ-015 The block SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-016 In IDLE or DONE, start high SHALL move the state to RUN at that edge, clear err_count, first_err_*, done and pass, and drive a=0, b=0.
REQ-017 In RUN, the block SHALL issue one operand pair per cycle, with b as the inner index and a as the outer index.
REQ-018 When b wraps from 2^ADDR_WIDTH-1 to 0, a SHALL increment in the same edge.
REQ-019 After issuing pair (2^ADDR_WIDTH-1, 2^ADDR_WIDTH-1), the block SHALL enter DRAIN; a and b SHALL hold their last values.
REQ-020 The expected value a+b, zero-extended to DATA_WIDTH, SHALL travel through a READ_LATENCY+1 deep pipeline together with its operands and a valid bit.
REQ-021 Each valid pipeline entry SHALL be compared against sum exactly READ_LATENCY edges after its operands are presented.
REQ-022 On each mismatch, err_count SHALL increment, saturating at 16'hFFFF.
REQ-023 On the first mismatch only, first_err_a and first_err_b SHALL capture that entry's operands.
REQ-024 DRAIN SHALL last until the pipeline holds no valid entries; the block SHALL then enter DONE with done=1.
REQ-025 done SHALL rise 2^(2*ADDR_WIDTH)+READ_LATENCY edges after the edge that samples start.
REQ-026 start SHALL be ignored while busy is high.
REQ-027 In DONE, a start SHALL begin a new sweep with no IDLE cycle in between.
REQ-028 pass SHALL be 0 whenever done is 0.

Reset
REQ-029 reset high SHALL force the state to IDLE regardless of current state, including mid-sweep.
REQ-030 reset SHALL set a, b, err_count, first_err_a, first_err_b, busy, done and pass to 0.
REQ-031 reset SHALL invalidate all pipeline entries; no comparison result computed before the reset SHALL affect state afterwards.
REQ-032 reset SHALL take priority over start in the same cycle.

Structure
REQ-033 The state enum, ERR_COUNT_WIDTH=16 and the default widths SHALL reside in a shared package, adder_test_pkg.
REQ-034 The expected-value delay line SHALL be one sub-module, sweep_expect_pipe, parameterised by depth and width.
REQ-035 The sub-module SHALL carry {valid, a, b, expected}.
REQ-036 The block SHALL instantiate no adder; it connects to rom_eight_bit_magnitude_adder at the testbench or top level.

Verification
REQ-037 Correct adder, start pulsed one cycle -> done after 65536+READ_LATENCY edges, pass=1, err_count=0; pair (255,255) compared against 510.
REQ-038 Adder model returning sum^1 only for a=3,b=5 -> err_count=1, first_err_a=3, first_err_b=5, pass=0.
REQ-039 Adder model driving sum=9'h1FF constantly -> err_count=16'hFFFF (saturated), first_err=(0,0), pass=0.
REQ-040 start re-pulsed at pair 1000 during RUN -> ignored; a/b sequence unbroken; done timing unchanged.
REQ-041 reset asserted at pair 100 -> next cycle state IDLE, a=b=0, busy=0, err_count=0; a new start gives a full clean sweep.
REQ-042 Bench parameterised with READ_LATENCY=2 and an adder delayed to match -> pass=1, done after 65538 edges.

Source files
------------

// File: rtl/adder_test_pkg.sv
`default_nettype none
// ============================================================================
// adder_test_pkg : shared state encoding and default widths for the sweep test
// Revision: 1.0
// ============================================================================
package adder_test_pkg;

  localparam int ERR_COUNT_WIDTH      = 16;
  localparam int DEFAULT_ADDR_WIDTH   = 8;
  localparam int DEFAULT_DATA_WIDTH   = 9;
  localparam int DEFAULT_READ_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_e;

  // One extra stage so the compare sees the entry after the adder's own latency.
  function automatic int expect_pipe_depth(input int read_latency);
    return read_latency + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_expect_pipe.sv
`default_nettype none
// ============================================================================
// sweep_expect_pipe : delay line carrying {valid, a, b, expected} per pair
// Revision: 1.0
// ============================================================================
module sweep_expect_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [DEPTH-1:0] stage_valid_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q [DEPTH];
  logic [WIDTH-1:0] data_q  [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             valid_d;
    logic [WIDTH-1:0] data_d;

    if (i == 0) begin : g_head
      assign valid_d = valid_i;
      assign data_d  = data_i;
    end else begin : g_tail
      assign valid_d = valid_q[i-1];
      assign data_d  = data_q[i-1];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q[i] <= 1'b0;
      end else begin
        valid_q[i] <= valid_d;
      end
    end

    // Payload is qualified by the valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
      data_q[i] <= data_d;
    end

    assign stage_valid_o[i] = valid_q[i];
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/adder_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// adder_sweep_sequencer : exhaustive a/b sweep of an external adder with checks
// Revision: 1.0
// ============================================================================
module adder_sweep_sequencer
  import adder_test_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [ADDR_WIDTH-1:0]      a,
  output logic [ADDR_WIDTH-1:0]      b,
  input  logic [DATA_WIDTH-1:0]      sum,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [ERR_COUNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]      first_err_a,
  output logic [ADDR_WIDTH-1:0]      first_err_b
);

  localparam int DEPTH  = expect_pipe_depth(READ_LATENCY);
  localparam int PIPE_W = 2 * ADDR_WIDTH + DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0]      OPND_MAX   = '1;
  localparam logic [ERR_COUNT_WIDTH-1:0] ERR_SAT    = '1;
  localparam logic [DEPTH-1:0]           LAST_STAGE = DEPTH'(1) << (DEPTH - 1);

  sweep_state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0]       a_q, a_d;
  logic [ADDR_WIDTH-1:0]       b_q, b_d;
  logic [ADDR_WIDTH-1:0]       fa_q, fa_d;
  logic [ADDR_WIDTH-1:0]       fb_q, fb_d;
  logic [ERR_COUNT_WIDTH-1:0]  err_q, err_d;

  logic                        push;
  logic [PIPE_W-1:0]           push_data;
  logic [DEPTH-1:0]            stage_valid;
  logic                        chk_valid;
  logic [PIPE_W-1:0]           chk_data;
  logic [ADDR_WIDTH-1:0]       chk_a;
  logic [ADDR_WIDTH-1:0]       chk_b;
  logic [DATA_WIDTH-1:0]       chk_exp;
  logic                        upstream_empty;
  logic                        mismatch;
  logic                        last_pair;

  assign push_data = {a_d, b_d, DATA_WIDTH'(a_d) + DATA_WIDTH'(b_d)};

  sweep_expect_pipe #(
    .DEPTH (DEPTH),
    .WIDTH (PIPE_W)
  ) u_expect_pipe (
    .clk           (clk),
    .reset         (reset),
    .valid_i       (push),
    .data_i        (push_data),
    .stage_valid_o (stage_valid),
    .valid_o       (chk_valid),
    .data_o        (chk_data)
  );

  assign {chk_a, chk_b, chk_exp} = chk_data;
  assign mismatch       = chk_valid && (sum != chk_exp);
  assign last_pair      = (a_q == OPND_MAX) && (b_q == OPND_MAX);
  // Only the last stage may still be occupied: it is compared on this edge.
  assign upstream_empty = ((stage_valid & ~LAST_STAGE) == '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    err_d   = err_q;
    push    = 1'b0;

    if (mismatch) begin
      if (err_q != ERR_SAT) begin
        err_d = err_q + ERR_COUNT_WIDTH'(1);
      end
      if (err_q == '0) begin
        fa_d = chk_a;
        fb_d = chk_b;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = '0;
          b_d     = '0;
          fa_d    = '0;
          fb_d    = '0;
          err_d   = '0;
          push    = 1'b1;
        end
      end
      ST_RUN: begin
        if (last_pair) begin
          state_d = upstream_empty ? ST_DONE : ST_DRAIN;
        end else begin
          push = 1'b1;
          b_d  = b_q + ADDR_WIDTH'(1);
          if (b_q == OPND_MAX) begin
            a_d = a_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (upstream_empty) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      err_q   <= err_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign first_err_a = fa_q;
  assign first_err_b = fb_q;
  assign err_count   = err_q;
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign pass        = done && (err_q == '0);

endmodule
`default_nettype wire
